// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: issues sequential fetches, tags responses with their PC and queues them for decode.
// Optional PREFETCH_PERF_EN adds saturating starvation and flush counters.
module inst_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  input  logic        if_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        fetch_halt
`ifdef PREFETCH_PERF_EN
  ,
  output logic [31:0] perf_starve,
  output logic [15:0] perf_flush
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic          r_started;
  logic [31:0]   r_fetchPc;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_liveOut;
  logic [CW-1:0] r_dropCnt;
  logic [PW-1:0] r_rdPtr;
  logic [PW-1:0] r_wrPtr;
  logic [PW-1:0] r_tagRdPtr;
  logic [PW-1:0] r_tagWrPtr;
  logic [31:0]   r_instMem [DEPTH];
  logic [31:0]   r_pcMem   [DEPTH];
  logic [31:0]   r_tagMem  [DEPTH];

  logic w_creditOk;
  logic w_issue;
  logic w_rspDrop;
  logic w_rspKeep;
  logic w_push;
  logic w_pop;

  // Both the queue slots and the stale-response drain share the DEPTH credit budget.
  assign w_creditOk = (({1'b0, r_count} + {1'b0, r_liveOut}) < DEPTH_W) &&
                      (({1'b0, r_liveOut} + {1'b0, r_dropCnt}) < DEPTH_W);

  assign imem_req_valid = r_started & ~redirect & ~fetch_halt & w_creditOk;
  assign imem_addr      = r_fetchPc;

  assign w_issue   = imem_req_valid & imem_req_ready;
  assign w_rspDrop = imem_rsp_valid & (r_dropCnt != '0);
  assign w_rspKeep = imem_rsp_valid & (r_dropCnt == '0);
  assign w_push    = w_rspKeep & ~redirect;
  assign w_pop     = if_valid & if_ready & ~redirect;

  assign if_valid = (r_count != '0);
  assign if_inst  = if_valid ? r_instMem[r_rdPtr] : 32'h0;
  assign if_pc    = if_valid ? r_pcMem[r_rdPtr]   : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_started  <= 1'b0;
      r_fetchPc  <= RESET_PC;
      r_count    <= '0;
      r_liveOut  <= '0;
      r_dropCnt  <= '0;
      r_rdPtr    <= '0;
      r_wrPtr    <= '0;
      r_tagRdPtr <= '0;
      r_tagWrPtr <= '0;
    end else begin
      r_started <= 1'b1;
      if (redirect) begin
        // A response landing this cycle settles against the old counters before the transfer.
        r_fetchPc  <= redirect_pc;
        r_count    <= '0;
        r_rdPtr    <= '0;
        r_wrPtr    <= '0;
        r_tagRdPtr <= '0;
        r_tagWrPtr <= '0;
        r_dropCnt  <= r_dropCnt - CW'(w_rspDrop) + r_liveOut - CW'(w_rspKeep);
        r_liveOut  <= '0;
      end else begin
        if (w_issue) begin
          r_fetchPc  <= r_fetchPc + 32'd1;
          r_tagWrPtr <= r_tagWrPtr + PTR_ONE;
        end
        if (w_push) begin
          r_wrPtr    <= r_wrPtr + PTR_ONE;
          r_tagRdPtr <= r_tagRdPtr + PTR_ONE;
        end
        if (w_pop) begin
          r_rdPtr <= r_rdPtr + PTR_ONE;
        end
        r_count   <= r_count + CW'(w_push) - CW'(w_pop);
        r_liveOut <= r_liveOut + CW'(w_issue) - CW'(w_rspKeep);
        r_dropCnt <= r_dropCnt - CW'(w_rspDrop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_issue) begin
      r_tagMem[r_tagWrPtr] <= r_fetchPc;
    end
    if (w_push) begin
      r_instMem[r_wrPtr] <= imem_rsp_data;
      r_pcMem[r_wrPtr]   <= r_tagMem[r_tagRdPtr];
    end
  end

`ifdef PREFETCH_PERF_EN
  logic [31:0] r_perfStarve;
  logic [15:0] r_perfFlush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perfStarve <= '0;
      r_perfFlush  <= '0;
    end else begin
      if (!if_valid && !fetch_halt && (r_perfStarve != '1)) begin
        r_perfStarve <= r_perfStarve + 32'd1;
      end
      if (redirect && (r_perfFlush != '1)) begin
        r_perfFlush <= r_perfFlush + 16'd1;
      end
    end
  end

  assign perf_starve = r_perfStarve;
  assign perf_flush  = r_perfFlush;
`endif

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Directed bench for inst_prefetch_queue with an in-order, fixed-latency instruction memory model.
module tb_inst_prefetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = 32'h0;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        if_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fetch_halt;

  int testsRun    = 0;
  int testsFailed = 0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } memReq_t;

  memReq_t memQ[$];
  int      cyc         = 0;
  int      memLatency  = 1;
  int      acceptCount = 0;
  int      baseAccept;
  int      waited;
  bit      gotValid;

  inst_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_inst        (if_inst),
    .if_pc          (if_pc),
    .if_ready       (if_ready),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .fetch_halt     (fetch_halt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memData(input logic [31:0] a);
    return a ^ 32'hDEAD0000;
  endfunction

  // Memory accepts on the rising edge and answers in order memLatency cycles later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      memQ.delete();
    end else begin
      if (imem_rsp_valid) void'(memQ.pop_front());
      cyc++;
      if (imem_req_valid && imem_req_ready) begin
        memQ.push_back('{addr: imem_addr, due: cyc + memLatency - 1});
        acceptCount++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && (memQ.size() > 0) && (memQ[0].due <= cyc)) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memData(memQ[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic ready, input logic ifReady, input logic halt);
    imem_req_ready = ready;
    if_ready       = ifReady;
    fetch_halt     = halt;
  endtask

  task automatic applyReset(input logic halt, input int latency, input logic ifReady);
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    memLatency  = latency;
    applyStimulus(1'b1, ifReady, halt);
    repeat (2) @(negedge clk);
    rst_n      = 1'b1;
    baseAccept = acceptCount;
  endtask

  task automatic waitIfValid(input int maxCycles, output bit got, output int n);
    got = 1'b0;
    n   = 0;
    for (int i = 0; i < maxCycles; i++) begin
      @(negedge clk);
      n++;
      if (if_valid) begin
        got = 1'b1;
        return;
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state and steady streaming at latency 1.
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("rst_req_valid", 32'(imem_req_valid), 32'd0);
    checkOutput("rst_addr",      imem_addr,           32'h0);
    checkOutput("rst_if_valid",  32'(if_valid),       32'd0);
    checkOutput("rst_if_inst",   if_inst,             32'h0);
    checkOutput("rst_if_pc",     if_pc,               32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("t1_req_valid", 32'(imem_req_valid), 32'd1);
    checkOutput("t1_addr0",     imem_addr,           32'h0);
    @(negedge clk);
    checkOutput("t1_not_yet", 32'(if_valid), 32'd0);
    @(negedge clk);
    checkOutput("t1_valid_c3", 32'(if_valid), 32'd1);
    checkOutput("t1_pc0",      if_pc,         32'h0);
    checkOutput("t1_inst0",    if_inst,       32'hDEAD0000);
    @(negedge clk);
    checkOutput("t1_pc1", if_pc, 32'h1);
    @(negedge clk);
    checkOutput("t1_pc2",   if_pc,   32'h2);
    checkOutput("t1_inst2", if_inst, 32'hDEAD0002);

    // Stalled decode: credit limit stops issue at DEPTH, queue holds 0..3 in order.
    applyReset(1'b0, 1, 1'b0);
    repeat (12) @(negedge clk);
    checkOutput("t2_accepts",   32'(acceptCount - baseAccept), 32'd4);
    checkOutput("t2_req_valid", 32'(imem_req_valid),           32'd0);
    if_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("t2_pc%0d", k), if_pc, 32'(k));
      @(negedge clk);
    end

    // Redirect with two stale requests in flight at latency 3.
    applyReset(1'b1, 3, 1'b1);
    @(negedge clk);
    fetch_halt = 1'b0;
    @(negedge clk);
    @(negedge clk);
    fetch_halt  = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    @(negedge clk);
    redirect   = 1'b0;
    fetch_halt = 1'b0;
    checkOutput("t3_accepts", 32'(acceptCount - baseAccept), 32'd2);
    checkOutput("t3_addr",    imem_addr,                     32'h100);
    #1;
    checkOutput("t3_req_valid", 32'(imem_req_valid), 32'd1);
    waitIfValid(20, gotValid, waited);
    checkOutput("t3_got_valid", 32'(gotValid), 32'd1);
    checkOutput("t3_wait",      32'(waited),   32'd4);
    checkOutput("t3_pc",        if_pc,         32'h100);
    checkOutput("t3_inst",      if_inst,       32'hDEAD0100);
    @(negedge clk);
    checkOutput("t3_pc_next", if_pc, 32'h101);

    // Redirect coinciding with a response and a pop while two entries are queued.
    applyReset(1'b0, 2, 1'b0);
    repeat (5) @(negedge clk);
    checkOutput("t4_head_valid", 32'(if_valid), 32'd1);
    checkOutput("t4_head_pc",    if_pc,         32'h0);
    checkOutput("t4_rsp_now",    32'(imem_rsp_valid), 32'd1);
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    if_ready    = 1'b1;
    #1;
    checkOutput("t4_req_blocked", 32'(imem_req_valid), 32'd0);
    @(negedge clk);
    redirect = 1'b0;
    checkOutput("t4_flushed", 32'(if_valid), 32'd0);
    checkOutput("t4_nop",     if_inst,       32'h0);
    checkOutput("t4_addr",    imem_addr,     32'h200);
    waitIfValid(20, gotValid, waited);
    checkOutput("t4_got_valid", 32'(gotValid), 32'd1);
    checkOutput("t4_wait",      32'(waited),   32'd3);
    checkOutput("t4_pc",        if_pc,         32'h200);
    checkOutput("t4_inst",      if_inst,       32'hDEAD0200);

    // Address wrap, then halt lets the queue drain with no new requests.
    applyReset(1'b1, 1, 1'b1);
    @(negedge clk);
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    @(negedge clk);
    redirect   = 1'b0;
    fetch_halt = 1'b0;
    checkOutput("t5_addr_max", imem_addr, 32'hFFFF_FFFF);
    @(negedge clk);
    checkOutput("t5_addr_wrap", imem_addr, 32'h0);
    fetch_halt = 1'b1;
    baseAccept = acceptCount;
    #1;
    checkOutput("t5_halt_req", 32'(imem_req_valid), 32'd0);
    @(negedge clk);
    checkOutput("t5_valid", 32'(if_valid), 32'd1);
    checkOutput("t5_pc",    if_pc,         32'hFFFF_FFFF);
    checkOutput("t5_inst",  if_inst,       32'h2152FFFF);
    @(negedge clk);
    checkOutput("t5_drained", 32'(if_valid), 32'd0);
    checkOutput("t5_nop",     if_inst,       32'h0);
    repeat (5) @(negedge clk);
    checkOutput("t5_no_accepts", 32'(acceptCount - baseAccept), 32'd0);
    checkOutput("t5_addr_hold",  imem_addr,                     32'h0);

    // Asynchronous reset in the middle of a stream with responses outstanding.
    applyReset(1'b0, 3, 1'b0);
    repeat (8) @(negedge clk);
    checkOutput("t6_pre_valid", 32'(if_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_if_valid",   32'(if_valid),       32'd0);
    checkOutput("t6_if_inst",    if_inst,             32'h0);
    checkOutput("t6_if_pc",      if_pc,               32'h0);
    checkOutput("t6_req_valid",  32'(imem_req_valid), 32'd0);
    checkOutput("t6_addr",       imem_addr,           32'h0);
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    if_ready = 1'b1;
    @(negedge clk);
    checkOutput("t6_restart_valid", 32'(imem_req_valid), 32'd1);
    checkOutput("t6_restart_addr",  imem_addr,           32'h0);
    waitIfValid(20, gotValid, waited);
    checkOutput("t6_got_valid", 32'(gotValid), 32'd1);
    checkOutput("t6_pc",        if_pc,         32'h0);
    checkOutput("t6_inst",      if_inst,       32'hDEAD0000);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
